// File: rtl/mcp_spi_pkg.sv
// Shared types and constants for the MCP23S17 SPI sequencer and its expander front-ends.
package mcp_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StSetup,
        StSend,
        StWaitRx,
        StGuard
    } state_e;

    localparam logic [3:0] OpcodePrefix = 4'b0100;

    localparam logic RwWrite = 1'b0;
    localparam logic RwRead  = 1'b1;

    // MCP23S17 register map (IOCON.BANK = 0)
    localparam logic [7:0] RegIodira = 8'h00;
    localparam logic [7:0] RegIodirb = 8'h01;
    localparam logic [7:0] RegIocon  = 8'h0A;
    localparam logic [7:0] RegGppua  = 8'h0C;
    localparam logic [7:0] RegGppub  = 8'h0D;
    localparam logic [7:0] RegGpioa  = 8'h12;
    localparam logic [7:0] RegGpiob  = 8'h13;
    localparam logic [7:0] RegOlata  = 8'h14;
    localparam logic [7:0] RegOlatb  = 8'h15;

    function automatic logic [7:0] mcp_opcode(logic [2:0] hwaddr, logic rw);
        return {OpcodePrefix, hwaddr, rw};
    endfunction

endpackage

// File: rtl/mcp_spi_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the served index on an advance strobe.
module rr_arbiter
    import mcp_spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IdxW-1:0]    adv_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    grant_idx,
    output logic               any_grant
);

    logic [IdxW-1:0] ptr;
    int              cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(ptr) + i;
            if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = IdxW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (adv_idx == IdxW'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mcp_spi_arbiter.sv
// Shares one byte-level SPI master between NUM_REQ MCP23S17 clients, framing
// opcode/register/data with CS guard time. Optional per-byte abort: MCP_SPI_ARB_TIMEOUT_EN.
module mcp_spi_arbiter
    import mcp_spi_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GUARD = 32,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [3*NUM_REQ-1:0] req_hwaddr,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_err,
    output logic [7:0]           rdata,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 busy,
    output logic [7:0]           tx_byte,
    output logic                 tx_dv,
    input  logic                 tx_ready,
    input  logic                 rx_dv,
    input  logic [7:0]           rx_byte
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state;
    logic [IdxW-1:0]    idx;
    logic               rw;
    logic [2:0]         hwaddr;
    logic [7:0]         regad;
    logic [7:0]         wdata;
    logic [1:0]         k;
    logic [15:0]        cnt;
    logic [7:0]         byte_k;
    logic [NUM_REQ-1:0] grant;
    logic [IdxW-1:0]    grant_idx;
    logic               any_grant;
    logic               frame_done;
    logic               advance;

    assign frame_done = (state == StWaitRx) && rx_dv && (k == 2'd2);

`ifdef MCP_SPI_ARB_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        timeout_hit;

    assign timeout_hit = ((state == StSend) || (state == StWaitRx)) && (tcnt > 32'(TIMEOUT));
    assign advance     = frame_done || timeout_hit;

    // Restarts on every received byte so the limit applies per byte, not per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if ((state == StSend) || ((state == StWaitRx) && !rx_dv)) begin
            tcnt <= tcnt + 32'd1;
        end else begin
            tcnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign advance        = frame_done;
    assign req_err        = '0;
`endif

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (advance),
        .adv_idx  (idx),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any_grant(any_grant)
    );

    always_comb begin
        byte_k = 8'h00;
        case (k)
            2'd0:    byte_k = mcp_opcode(hwaddr, rw);
            2'd1:    byte_k = regad;
            default: byte_k = (rw == RwRead) ? 8'h00 : wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cs_n     <= '1;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
            req_done <= '0;
            rdata    <= 8'h00;
            busy     <= 1'b0;
            idx      <= '0;
            rw       <= RwWrite;
            hwaddr   <= '0;
            regad    <= '0;
            wdata    <= '0;
            k        <= '0;
            cnt      <= '0;
`ifdef MCP_SPI_ARB_TIMEOUT_EN
            req_err  <= '0;
`endif
        end else begin
            tx_dv    <= 1'b0;
            req_done <= '0;
`ifdef MCP_SPI_ARB_TIMEOUT_EN
            req_err  <= '0;
`endif
            case (state)
                StIdle: begin
                    if (any_grant) begin
                        idx    <= grant_idx;
                        rw     <= req_rw[grant_idx];
                        hwaddr <= req_hwaddr[3*int'(grant_idx) +: 3];
                        regad  <= req_reg[8*int'(grant_idx) +: 8];
                        wdata  <= req_wdata[8*int'(grant_idx) +: 8];
                        cs_n   <= ~grant;
                        busy   <= 1'b1;
                        state  <= StGrant;
                    end
                end
                StGrant: begin
                    cnt   <= '0;
                    k     <= '0;
                    state <= StSetup;
                end
                StSetup: begin
                    if (cnt + 16'd1 >= 16'(CS_SETUP)) state <= StSend;
                    else                              cnt   <= cnt + 16'd1;
                end
                StSend: begin
                    if (tx_ready) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= byte_k;
                        state   <= StWaitRx;
                    end
                end
                StWaitRx: begin
                    if (rx_dv) begin
                        if (k != 2'd2) begin
                            k     <= k + 2'd1;
                            state <= StSend;
                        end else begin
                            if (rw == RwRead) rdata <= rx_byte;
                            cs_n          <= '1;
                            req_done[idx] <= 1'b1;
                            cnt           <= '0;
                            state         <= StGuard;
                        end
                    end
                end
                StGuard: begin
                    if (cnt + 16'd1 >= 16'(CS_GUARD)) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef MCP_SPI_ARB_TIMEOUT_EN
            // Abort overrides whatever the byte phase decided this cycle.
            if (timeout_hit) begin
                cs_n          <= '1;
                tx_dv         <= 1'b0;
                req_done      <= '0;
                req_done[idx] <= 1'b1;
                req_err[idx]  <= 1'b1;
                cnt           <= '0;
                state         <= StGuard;
            end
`endif
        end
    end

endmodule
